ssd_scan_driver: RTL and testbench
==================================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clk_i cycles per digit slot (minimum 2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port value_i  input  4*NUM_DIGITS  hex nibbles; nibble k [4k+3:4k] drives digit k, digit 0 least significant.
REQ-006 SHALL have port dp_i  input  NUM_DIGITS  decimal point per digit, active-high.
REQ-007 SHALL have port load_i  input  1  single-cycle strobe; captures value_i/dp_i into the pending register.
REQ-008 SHALL have port en_i  input  1  display enable.
REQ-009 SHALL have port seg_o  output  7  segments, bit0 = top (seg 1), bit1..bit5 = segs 2..6 clockwise, bit6 = middle (seg 7), active-high.
REQ-010 SHALL have port dp_o  output  1  decimal point of the active digit.
REQ-011 SHALL have port dig_o  output  NUM_DIGITS  one-hot digit select, active-high.
REQ-012 SHALL have port upd_o  output  1  one-cycle pulse when the pending value is committed to display.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; its terminal cycle advances digit index idx, NUM_DIGITS-1 wrapping to 0.
REQ-014 Frame boundary = terminal cycle while idx==NUM_DIGITS-1; with NUM_DIGITS=1 every terminal cycle is a boundary.
REQ-015 load_i SHALL set pending_valid and overwrite the pending register; multiple loads within a frame: last wins.
REQ-016 At a frame boundary with pending_valid=1, pending SHALL be copied to the display register, pending_valid cleared, upd_o pulsed on the next cycle.
REQ-017 load_i coincident with a boundary: the boundary commits the prior pending contents (if valid); the new load SHALL be held pending for the next boundary.
REQ-018 seg_o/dp_o/dig_o SHALL be registered: one cycle latency from idx/display register.
REQ-019 Encoding (hex of seg_o) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7C 7:07 8:7F 9:67 A:77 b:7C C:58 d:5E E:79 F:71.
REQ-020 Dead time: dig_o SHALL be all-zero in the output cycle corresponding to prescaler==0 (anti-ghosting); seg_o shows the new digit.
REQ-021 en_i=0 SHALL force dig_o=0, seg_o=7'h40, dp_o=0; prescaler, idx and the load/commit path keep running.
REQ-022 dig_o SHALL never have more than one bit set.

Reset
REQ-023 rst_ni low SHALL immediately force seg_o=7'h40, dp_o=0, dig_o=0, upd_o=0.
REQ-024 Reset SHALL clear prescaler, idx, display register (all nibbles 0, dp 0) and pending_valid.
REQ-025 Reset mid-frame SHALL discard pending data; no upd_o pulse after release until a new load commits.
REQ-026 First slot after release SHALL be digit 0.

Configuration
REQ-027 Macro SSD_SCAN_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-028 Defined: digit k>0 SHALL output seg_o=0 when nibbles k..NUM_DIGITS-1 are all zero; digit 0 never blanked; dp_o and dig_o unaffected.
REQ-029 Undefined: every digit SHALL be decoded per REQ-019; no blanking logic synthesised.

Verification
REQ-030 NUM_DIGITS=4, SCAN_DIV=4, reset released, en_i=1 -> dig_o cycles 0001,0010,0100,1000 (each slot 1 cycle 0000 + 3 active), seg_o=3F each digit.
REQ-031 load_i with value_i=16'h12AF, dp_i=4'b0100 mid-frame -> display unchanged until boundary, upd_o one pulse, then seg_o 71,77,5B,06 for digits 0..3, dp_o=1 only on digit 2.
REQ-032 Two loads (16'h1111 then 16'h2222) in one frame -> single upd_o, 2222 displayed; load 16'h3333 on boundary cycle -> 2222 frame, then 3333 next frame with second upd_o.
REQ-033 With SSD_SCAN_LZ_BLANK_EN, value 16'h0050 -> digits 3,2 seg_o=00, digit1 6D, digit0 3F; value 16'h0000 -> only digit 0 shows 3F; without macro, 0050 -> 3F,3F,6D,3F.
REQ-034 en_i=0 for 10 cycles mid-frame -> dig_o=0, seg_o=40; re-enable resumes at the idx the free-running scan has reached.
REQ-035 rst_ni asserted during slot of digit 2 with pending load -> outputs 40/0/0 asynchronously; after release digit 0 shows 3F, no upd_o.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered, frame-aligned display updates.
// Optional leading-zero blanking: define SSD_SCAN_LZ_BLANK_EN.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    upd_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DASH = 7'h40;

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    upd_q, upd_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic       tick, boundary, commit;
  logic [3:0] nib_sel;
  logic       dp_sel;
  logic       blank_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7C;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h67;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h58;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_sel = disp_val_q[4*k +: 4];
        dp_sel  = disp_dp_q[k];
      end
    end
  end

`ifdef SSD_SCAN_LZ_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    blank_sel  = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && (disp_val_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) blank_sel = upper_zero;
    end
  end
`else
  assign blank_sel = 1'b0;
`endif

  always_comb begin
    tick     = (presc_q == PRE_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    commit   = boundary && pend_vld_q;

    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // A load on the boundary cycle lands in pending after the old contents commit.
    pend_val_d = load_i ? value_i : pend_val_q;
    pend_dp_d  = load_i ? dp_i : pend_dp_q;
    pend_vld_d = load_i || (pend_vld_q && !boundary);

    disp_val_d = commit ? pend_val_q : disp_val_q;
    disp_dp_d  = commit ? pend_dp_q : disp_dp_q;
    upd_d      = commit;

    dig_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) dig_d[k] = (idx_q == IDX_W'(k));
    if (presc_q == '0) dig_d = '0;
    seg_d = blank_sel ? 7'h00 : hex_to_seg(nib_sel);
    dp_d  = dp_sel;

    if (!en_i) begin
      dig_d = '0;
      seg_d = SEG_DASH;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      upd_q      <= 1'b0;
      seg_q      <= SEG_DASH;
      dp_q       <= 1'b0;
      dig_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      upd_q      <= upd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign dig_o = dig_q;
  assign upd_o = upd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver (NUM_DIGITS=4, SCAN_DIV=4): scan order, commit timing,
// encodings, enable gating, reset; expectations follow SSD_SCAN_LZ_BLANK_EN when defined.
module tb_ssd_scan_driver;

  localparam int NONE = -100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        upd;

  int vectors = 0;
  int miscompares = 0;
  int frame_no = 0;

  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .value_i (value),
    .dp_i    (dp_in),
    .load_i  (load),
    .en_i    (en),
    .seg_o   (seg),
    .dp_o    (dp),
    .dig_o   (dig),
    .upd_o   (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " seg"}, seg, 7'h40);
    chk({tag, " dp"}, 7'(dp), 7'h0);
    chk({tag, " dig"}, 7'(dig), 7'h0);
    chk({tag, " upd"}, 7'(upd), 7'h0);
  endtask

  // One 16-cycle frame starting at digit 0. segs packs {d3,d2,d1,d0}; loads share dp value ld.
  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps, input logic exp_upd,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb,
                           input int lc, input logic [15:0] vc,
                           input logic [3:0] ld, input int en_off, input int en_len);
    frame_no++;
    for (int i = 0; i < 16; i++) begin
      int   slot;
      logic off;
      slot = i / 4;
      @(posedge clk); #1;
      off = (i > en_off) && (i <= en_off + en_len);
      chk($sformatf("f%0d c%0d dig", frame_no, i), 7'(dig),
          (off || (i % 4 == 0)) ? 7'h0 : 7'(4'b0001 << slot));
      chk($sformatf("f%0d c%0d seg", frame_no, i), seg, off ? 7'h40 : segs[7*slot +: 7]);
      chk($sformatf("f%0d c%0d dp", frame_no, i), 7'(dp), off ? 7'h0 : 7'(dps[slot]));
      chk($sformatf("f%0d c%0d upd", frame_no, i), 7'(upd), (i == 15) ? 7'(exp_upd) : 7'h0);
      load = 1'b0;
      if (i == la) begin load = 1'b1; value = va; dp_in = ld; end
      if (i == lb) begin load = 1'b1; value = vb; dp_in = ld; end
      if (i == lc) begin load = 1'b1; value = vc; dp_in = ld; end
      if (i == en_off) en = 1'b0;
      if (i == en_off + en_len) en = 1'b1;
    end
  endtask

  initial begin
    logic [27:0] seg_0050, seg_0000;
`ifdef SSD_SCAN_LZ_BLANK_EN
    seg_0050 = {7'h00, 7'h00, 7'h6D, 7'h3F};
    seg_0000 = {7'h00, 7'h00, 7'h00, 7'h3F};
`else
    seg_0050 = {7'h3F, 7'h3F, 7'h6D, 7'h3F};
    seg_0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle scan after reset: all zeros displayed
    run_frame({4{7'h3F}}, 4'h0, 1'b0, NONE, 16'h0, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    // Mid-frame load stays pending until the boundary
    run_frame({4{7'h3F}}, 4'h0, 1'b1, 5, 16'h12AF, NONE, 16'h0, NONE, 16'h0, 4'b0100, NONE, 0);
    // Two loads (last wins) plus a load on the boundary cycle
    run_frame({7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100, 1'b1,
              2, 16'h1111, 7, 16'h2222, 14, 16'h3333, 4'h0, NONE, 0);
    run_frame({4{7'h5B}}, 4'h0, 1'b1, NONE, 16'h0, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    // Enable dropped for 10 cycles while a load goes through
    run_frame({4{7'h4F}}, 4'h0, 1'b1, 1, 16'h0050, NONE, 16'h0, NONE, 16'h0, 4'h0, 3, 10);
    run_frame(seg_0050, 4'h0, 1'b1, 4, 16'h0000, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    run_frame(seg_0000, 4'h0, 1'b1, 8, 16'h4E9C, NONE, 16'h0, NONE, 16'h0, 4'b1001, NONE, 0);
    run_frame({7'h66, 7'h79, 7'h67, 7'h58}, 4'b1001, 1'b1,
              10, 16'h8D07, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    run_frame({7'h7F, 7'h5E, 7'h3F, 7'h07}, 4'h0, 1'b1,
              3, 16'h6B35, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    run_frame({7'h7C, 7'h7C, 7'h4F, 7'h6D}, 4'h0, 1'b0,
              NONE, 16'h0, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);

    // Reset during digit 2 with a load pending
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      load = (i == 1);
      if (i == 1) begin value = 16'h1234; dp_in = 4'b1111; end
    end
    load = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("held reset");
    #2 rst_n = 1'b1;
    run_frame(seg_0000, 4'h0, 1'b0, NONE, 16'h0, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);
    run_frame(seg_0000, 4'h0, 1'b0, NONE, 16'h0, NONE, 16'h0, NONE, 16'h0, 4'h0, NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
